pll_reset_sequencer: RTL and testbench

//   Sits on the other end of the system PLL's rst/locked interface: drives the PLL reset
//   and watches its lock output.

---
 rtl/pll_reset_sequencer_if.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 126 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// PLL sequencer interface: PLL rst/locked pair, status clear and core-side reset/status outputs.
interface pll_reset_sequencer_if #(
   parameter int unsigned RETRY_W = 4
);
   logic               pll_locked;
   logic               clear_status;
   logic               pll_rst;
   logic               sys_reset;
   logic               ready;
   logic               lock_lost;
   logic [RETRY_W-1:0] retry_count;

   // System / board side: supplies lock and clear, observes resets and status
   modport master (
      output pll_locked,
      output clear_status,
      input  pll_rst,
      input  sys_reset,
      input  ready,
      input  lock_lost,
      input  retry_count
   );

   // Sequencer side
   modport slave (
      input  pll_locked,
      input  clear_status,
      output pll_rst,
      output sys_reset,
      output ready,
      output lock_lost,
      output retry_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, requires a stable lock window
// before releasing the core reset, retries on lock timeout and re-resets on loss of lock.
module pll_reset_sequencer #(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 1000000,
   parameter int unsigned STABLE_CYCLES  = 1024,
   parameter int unsigned CNT_W          = 20,
   parameter int unsigned RETRY_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pll_reset_sequencer_if.slave  io_bus
);

   typedef enum logic [1:0] {StPllReset, StWaitLock, StStable, StRun} state_e;

   localparam logic [CNT_W-1:0]   PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   StableLast  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RetryMax    = '1;

   state_e             r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;
   logic               r_sync1, r_sync2;
   logic               w_lk;
   logic               w_timeout, w_lost;
   logic               r_pll_rst, r_sys_reset, r_ready, r_lock_lost;
   logic [RETRY_W-1:0] r_retry;
   logic               w_lock_lost_d;
   logic [RETRY_W-1:0] w_retry_d;

   assign w_lk = r_sync2;

   // Two-flop synchroniser for the asynchronous lock indication
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= io_bus.pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // Next state, counter and event strobes; counter clears on any state change
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt + CNT_W'(1);
      w_timeout = 1'b0;
      w_lost    = 1'b0;
      unique case (r_state)
         StPllReset: begin
            if (r_cnt == PllRstLast) w_state_d = StWaitLock;
         end
         StWaitLock: begin
            if (w_lk) begin
               w_state_d = StStable;
            end else if (r_cnt == TimeoutLast) begin
               w_state_d = StPllReset;
               w_timeout = 1'b1;
            end
         end
         StStable: begin
            if (!w_lk) begin
               w_state_d = StWaitLock;
            end else if (r_cnt == StableLast) begin
               w_state_d = StRun;
            end
         end
         StRun: begin
            // Counter is unused in RUN; hold it so it cannot wrap
            w_cnt_d = r_cnt;
            if (!w_lk) begin
               w_state_d = StPllReset;
               w_lost    = 1'b1;
            end
         end
         default: w_state_d = StPllReset;
      endcase
      if (w_state_d != r_state) w_cnt_d = '0;
   end

   // Sticky status: a set or increment in the same cycle beats clear_status
   always_comb begin
      w_retry_d     = r_retry;
      w_lock_lost_d = r_lock_lost;
      if (w_timeout) begin
         if (r_retry != RetryMax) w_retry_d = r_retry + RETRY_W'(1);
      end else if (io_bus.clear_status) begin
         w_retry_d = '0;
      end
      if (w_lost) begin
         w_lock_lost_d = 1'b1;
      end else if (io_bus.clear_status) begin
         w_lock_lost_d = 1'b0;
      end
   end

   // State, counter, status and registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= StPllReset;
         r_cnt       <= '0;
         r_pll_rst   <= 1'b1;
         r_sys_reset <= 1'b1;
         r_ready     <= 1'b0;
         r_lock_lost <= 1'b0;
         r_retry     <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_pll_rst   <= (w_state_d == StPllReset);
         r_sys_reset <= (w_state_d != StRun);
         r_ready     <= (w_state_d == StRun);
         r_lock_lost <= w_lock_lost_d;
         r_retry     <= w_retry_d;
      end
   end

   assign io_bus.pll_rst     = r_pll_rst;
   assign io_bus.sys_reset   = r_sys_reset;
   assign io_bus.ready       = r_ready;
   assign io_bus.lock_lost   = r_lock_lost;
   assign io_bus.retry_count = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: deadline-based reference model checked every cycle,
// directed scenarios pinned by literal expectations, then randomized lock/clear/reset traffic.
module tb_pll_reset_sequencer;

   localparam int unsigned P  = 4;
   localparam int unsigned T  = 32;
   localparam int unsigned S  = 8;
   localparam int unsigned RW = 2;
   localparam int          RMAX = (1 << RW) - 1;

   localparam int MPr = 0, MWait = 1, MStable = 2, MRun = 3;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   pll_reset_sequencer_if #(.RETRY_W(RW)) bus ();

   pll_reset_sequencer #(
      .PLL_RST_CYCLES (P),
      .LOCK_TIMEOUT   (T),
      .STABLE_CYCLES  (S),
      .CNT_W          (20),
      .RETRY_W        (RW)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: each phase has an entry edge t0 and a deadline measured in edges
   // since entry; lk is the lock input delayed by two edges.
   int   cyc;
   int   t0;
   int   age;
   int   mode;
   int   nxt;
   int   m_retry;
   bit   m_lost;
   bit   m_s1, m_s2, m_lk;
   bit   m_tmo, m_drop;
   bit   mvalid;

   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         mode    = MPr;
         t0      = cyc;
         m_s1    = 1'b0;
         m_s2    = 1'b0;
         m_lost  = 1'b0;
         m_retry = 0;
         mvalid  = 1'b1;
      end else if (mvalid) begin
         m_lk   = m_s2;
         m_s2   = m_s1;
         m_s1   = bus.pll_locked;
         age    = cyc - t0;
         m_tmo  = 1'b0;
         m_drop = 1'b0;
         nxt    = mode;
         case (mode)
            MPr:     if (age == P) nxt = MWait;
            MWait: begin
               if (m_lk) nxt = MStable;
               else if (age == T) begin
                  nxt   = MPr;
                  m_tmo = 1'b1;
               end
            end
            MStable: begin
               if (!m_lk) nxt = MWait;
               else if (age == S) nxt = MRun;
            end
            default: begin
               if (!m_lk) begin
                  nxt    = MPr;
                  m_drop = 1'b1;
               end
            end
         endcase
         if (nxt != mode) begin
            mode = nxt;
            t0   = cyc;
         end
         if (m_tmo) m_retry = (m_retry == RMAX) ? RMAX : m_retry + 1;
         else if (bus.clear_status) m_retry = 0;
         if (m_drop) m_lost = 1'b1;
         else if (bus.clear_status) m_lost = 1'b0;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (mvalid) begin
         chk("model pll_rst",     32'(bus.pll_rst),     32'(mode == MPr));
         chk("model sys_reset",   32'(bus.sys_reset),   32'(mode != MRun));
         chk("model ready",       32'(bus.ready),       32'(mode == MRun));
         chk("model lock_lost",   32'(bus.lock_lost),   32'(m_lost));
         chk("model retry_count", 32'(bus.retry_count), 32'(m_retry));
      end
   end

   task automatic do_reset(input logic lockval);
      rst_n            = 1'b0;
      bus.pll_locked   = lockval;
      bus.clear_status = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // From the release negedge, count samples with pll_rst / sys_reset still high;
   // optionally drop the lock input for one cycle starting at sample glitch_k.
   task automatic measure(input int glitch_k, output int n_pll, output int n_sys);
      bit pdone, sdone;
      n_pll = 0;
      n_sys = 0;
      pdone = 1'b0;
      sdone = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (!pdone) begin
            if (bus.pll_rst) n_pll++;
            else pdone = 1'b1;
         end
         if (!sdone) begin
            if (bus.sys_reset) n_sys++;
            else sdone = 1'b1;
         end
         if (k == glitch_k) bus.pll_locked = 1'b0;
         else if (k == glitch_k + 1) bus.pll_locked = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " pll_rst"},     32'(bus.pll_rst),     32'd1);
      chk({tag, " sys_reset"},   32'(bus.sys_reset),   32'd1);
      chk({tag, " ready"},       32'(bus.ready),       32'd0);
      chk({tag, " lock_lost"},   32'(bus.lock_lost),   32'd0);
      chk({tag, " retry_count"}, 32'(bus.retry_count), 32'd0);
   endtask

   initial begin
      int np, ns, rise1, rise2, hold;
      logic prev, lvl;
      n_chk            = 0;
      n_fail           = 0;
      rst_n            = 1'b0;
      bus.pll_locked   = 1'b0;
      bus.clear_status = 1'b0;

      // 1: lock present from the start
      do_reset(1'b1);
      chk_reset_outputs("reset");
      measure(-5, np, ns);
      chk("t1 pll_rst high cycles", 32'(np), 32'd4);
      chk("t1 sys_reset high cycles", 32'(ns), 32'd13);
      chk("t1 ready", 32'(bus.ready), 32'd1);
      chk("t1 lock_lost", 32'(bus.lock_lost), 32'd0);

      // 4: loss of lock in RUN, then relock
      bus.pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      chk("t4 sys_reset at M+1", 32'(bus.sys_reset), 32'd0);
      @(negedge clk);
      chk("t4 sys_reset at M+2", 32'(bus.sys_reset), 32'd1);
      chk("t4 ready at M+2", 32'(bus.ready), 32'd0);
      chk("t4 pll_rst at M+2", 32'(bus.pll_rst), 32'd1);
      chk("t4 lock_lost at M+2", 32'(bus.lock_lost), 32'd1);
      bus.pll_locked = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4 relock ready", 32'(bus.ready), 32'd1);
      chk("t4 lock_lost sticky", 32'(bus.lock_lost), 32'd1);
      bus.clear_status = 1'b1;
      @(negedge clk);
      bus.clear_status = 1'b0;
      chk("t5 lock_lost cleared", 32'(bus.lock_lost), 32'd0);

      // 3: one-cycle glitch while STABLE counter is at 5
      do_reset(1'b1);
      measure(8, np, ns);
      chk("t3 pll_rst high cycles", 32'(np), 32'd4);
      chk("t3 sys_reset high cycles", 32'(ns), 32'd20);
      chk("t3 retry_count", 32'(bus.retry_count), 32'd0);

      // 2: no lock ever, retries saturate
      do_reset(1'b0);
      prev  = 1'b1;
      rise1 = -1;
      rise2 = -1;
      for (int k = 0; k <= 150; k++) begin
         if (bus.pll_rst && !prev) begin
            if (rise1 < 0) rise1 = k;
            else if (rise2 < 0) rise2 = k;
         end
         prev = bus.pll_rst;
         if (k == 40)  chk("t2 retry 1", 32'(bus.retry_count), 32'd1);
         if (k == 76)  chk("t2 retry 2", 32'(bus.retry_count), 32'd2);
         if (k == 112) chk("t2 retry 3", 32'(bus.retry_count), 32'd3);
         if (k == 148) begin
            chk("t2 retry saturated", 32'(bus.retry_count), 32'd3);
            chk("t2 sys_reset held", 32'(bus.sys_reset), 32'd1);
         end
         @(negedge clk);
      end
      chk("t2 first re-pulse", 32'(rise1), 32'd36);
      chk("t2 re-pulse period", 32'(rise2 - rise1), 32'd36);

      // 5: clear_status coinciding with a timeout loses to the increment
      do_reset(1'b0);
      for (int k = 0; k <= 42; k++) begin
         if (k == 35) bus.clear_status = 1'b1;
         if (k == 36) begin
            bus.clear_status = 1'b0;
            chk("t5 increment beats clear", 32'(bus.retry_count), 32'd1);
         end
         if (k == 40) bus.clear_status = 1'b1;
         if (k == 41) begin
            bus.clear_status = 1'b0;
            chk("t5 idle clear", 32'(bus.retry_count), 32'd0);
         end
         @(negedge clk);
      end

      // 6: reset mid-STABLE and mid-RUN
      do_reset(1'b1);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("t6 stable");
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6 in run", 32'(bus.ready), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_outputs("t6 run");
      rst_n = 1'b1;

      // Randomized lock levels, glitches, clears and occasional resets
      hold = 0;
      lvl  = 1'b0;
      for (int it = 0; it < 2500; it++) begin
         if (hold == 0) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = lvl ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 50));
         end
         hold--;
         bus.pll_locked   = lvl;
         bus.clear_status = ($urandom_range(0, 15) == 0);
         rst_n            = ($urandom_range(0, 299) != 0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
